// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the register-file read/write ports and mul_div_unit.
// The master drives the request; the slave (the unit) returns the writeback.
interface mul_div_unit_if #(parameter int XLEN = 64);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] WriteData;
    logic [4:0]      rd;
    logic            RegWrite;

    modport master (
        output start, op, rs1_val, rs2_val, rd_in,
        input  busy, done, WriteData, rd, RegWrite
    );
    modport slave (
        input  start, op, rs1_val, rs2_val, rd_in,
        output busy, done, WriteData, rd, RegWrite
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV64M multiply/divide: 64 shift-add or restoring-divide steps on magnitudes,
// sign fix-up afterwards; divide-by-zero and signed overflow resolve without iterating.
module mul_div_unit (
    input  logic           clk,
    input  logic           reset,
    mul_div_unit_if.slave  bus
);
    localparam int XLEN = 64;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_q;
    logic [2:0]        op_q;
    logic              neg_q, rem_neg_q;
    logic [5:0]        cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opnd_q, res_q, wdata_q;
    logic [4:0]        rd_q, rd_o_q;
    logic              busy_q, done_q, regwr_q;

    // Request decode on the live inputs (only used on the accepting edge)
    logic            op_div, sa, sb, a_neg, b_neg, b_zero, ovf, special;
    logic [XLEN-1:0] mag_a, mag_b, spec_res;

    always_comb begin
        op_div  = bus.op[2];
        sa      = (bus.op == 3'b001) || (bus.op == 3'b010) || (bus.op == 3'b100) || (bus.op == 3'b110);
        sb      = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
        a_neg   = sa && bus.rs1_val[XLEN-1];
        b_neg   = sb && bus.rs2_val[XLEN-1];
        mag_a   = a_neg ? -bus.rs1_val : bus.rs1_val;
        mag_b   = b_neg ? -bus.rs2_val : bus.rs2_val;
        b_zero  = (bus.rs2_val == '0);
        ovf     = ((bus.op == 3'b100) || (bus.op == 3'b110)) &&
                  (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.rs2_val);
        special = op_div && (b_zero || ovf);
        // op[1] distinguishes REM/REMU from DIV/DIVU
        if (b_zero) spec_res = bus.op[1] ? bus.rs1_val : '1;
        else        spec_res = bus.op[1] ? '0 : bus.rs1_val;
    end

    // One iteration step; acc_q holds {hi, lo} = {partial product, multiplier}
    // for multiply and {remainder, dividend/quotient} for divide.
    logic [XLEN:0]     mul_sum, rem_sh;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_nx;
    logic [2*XLEN-1:0] mul_nxt, div_nxt;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
        mul_nxt = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
        rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rem_ge  = rem_sh >= {1'b0, opnd_q};
        rem_nx  = rem_ge ? XLEN'(rem_sh - {1'b0, opnd_q}) : rem_sh[XLEN-1:0];
        div_nxt = {rem_nx, acc_q[XLEN-2:0], rem_ge};
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_res;

    always_comb begin
        prod = neg_q     ? -acc_q                   : acc_q;
        quo  = neg_q     ? -acc_q[XLEN-1:0]         : acc_q[XLEN-1:0];
        rem  = rem_neg_q ? -acc_q[2*XLEN-1:XLEN]    : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 fix_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo;
            default:                fix_res = rem;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            res_q     <= '0;
            rd_q      <= '0;
            wdata_q   <= '0;
            rd_o_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            regwr_q   <= 1'b0;
        end else begin
            busy_q  <= (state_q != IDLE);
            done_q  <= (state_q == DONE);
            regwr_q <= (state_q == DONE) && (rd_q != '0);
            if (state_q == DONE) begin
                wdata_q <= res_q;
                rd_o_q  <= rd_q;
            end
            case (state_q)
                IDLE: if (bus.start) begin
                    op_q      <= bus.op;
                    rd_q      <= bus.rd_in;
                    neg_q     <= a_neg ^ b_neg;
                    rem_neg_q <= a_neg;
                    opnd_q    <= op_div ? mag_b : mag_a;
                    acc_q     <= {{XLEN{1'b0}}, (op_div ? mag_a : mag_b)};
                    if (special) begin
                        res_q   <= spec_res;
                        state_q <= DONE;
                    end else begin
                        cnt_q   <= 6'd63;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= op_q[2] ? div_nxt : mul_nxt;
                    cnt_q <= cnt_q - 6'd1;
                    if (cnt_q == '0) state_q <= FIX;
                end
                FIX: begin
                    res_q   <= fix_res;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.WriteData = wdata_q;
    assign bus.rd        = rd_o_q;
    assign bus.RegWrite  = regwr_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases, ignored starts,
// mid-operation reset and randomized ops against a plain-arithmetic reference.
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = '1;

    mul_div_unit_if bus();
    mul_div_unit dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [63:0]  r;
        case (op)
            3'd0: begin p = {64'b0, a} * {64'b0, b}; r = p[63:0]; end
            3'd1: begin p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); r = p[127:64]; end
            3'd2: begin p = $signed({{64{a[63]}}, a}) * $signed({64'b0, b}); r = p[127:64]; end
            3'd3: begin p = {64'b0, a} * {64'b0, b}; r = p[127:64]; end
            3'd4: if (b == 0) r = ONES; else if (a == MIN && b == ONES) r = a; else r = $signed(a) / $signed(b);
            3'd5: r = (b == 0) ? ONES : a / b;
            3'd6: if (b == 0) r = a; else if (a == MIN && b == ONES) r = 0; else r = $signed(a) % $signed(b);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == MIN && b == ONES))) return 1;
        return 66;
    endfunction

    // Entered #1 after a rising edge with the unit idle; glitch>0 pulses a foreign start at that edge
    task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rdi, input int glitch);
        int lat = 0;
        bus.op = op; bus.rs1_val = a; bus.rs2_val = b; bus.rd_in = rdi; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.rs1_val = {$urandom, $urandom}; bus.rs2_val = {$urandom, $urandom};
        bus.op = 3'($urandom); bus.rd_in = 5'($urandom);
        for (int n = 1; n <= 80 && lat == 0; n++) begin
            if (n == glitch) bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (n == 1) chk("busy", 64'(bus.busy), 64'(ref_lat(op, a, b) > 0));
            if (bus.done) lat = n;
        end
        chk("latency", 64'(lat), 64'(ref_lat(op, a, b)));
        chk("wdata", bus.WriteData, ref_res(op, a, b));
        chk("rd", 64'(bus.rd), 64'(rdi));
        chk("regwrite", 64'(bus.RegWrite), 64'(rdi != 0));
        @(posedge clk); #1;
        chk("pulse", 64'(bus.done), 64'(0));
        chk("idle", 64'(bus.busy), 64'(0));
    endtask

    initial begin
        bus.start = 1'b0; bus.op = '0; bus.rs1_val = '0; bus.rs2_val = '0; bus.rd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 0);
        chk("rst_done", 64'(bus.done), 0);
        chk("rst_wdata", bus.WriteData, 0);
        chk("rst_rd", 64'(bus.rd), 0);
        chk("rst_regwr", 64'(bus.RegWrite), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(3'd0, 64'd12, 64'd13, 5'd5, 0);
        run_op(3'd1, ONES, ONES, 5'd1, 0);
        run_op(3'd3, ONES, ONES, 5'd2, 0);
        run_op(3'd2, ONES, 64'd2, 5'd3, 0);
        run_op(3'd4, -64'd14, 64'd5, 5'd4, 0);
        run_op(3'd6, -64'd14, 64'd5, 5'd6, 0);
        run_op(3'd5, 64'd14, 64'd5, 5'd7, 0);
        run_op(3'd7, 64'd14, 64'd5, 5'd8, 0);
        run_op(3'd4, 64'd7, 64'd0, 5'd9, 0);
        run_op(3'd6, 64'd7, 64'd0, 5'd10, 1);
        run_op(3'd4, MIN, ONES, 5'd11, 0);
        run_op(3'd6, MIN, ONES, 5'd12, 0);
        run_op(3'd0, 64'd1000, 64'd77, 5'd13, 10);
        run_op(3'd5, 64'd99, 64'd10, 5'd0, 66);

        // Reset in the middle of a divide
        bus.op = 3'd4; bus.rs1_val = 64'd1000; bus.rs2_val = 64'd7; bus.rd_in = 5'd3; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (30) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_busy", 64'(bus.busy), 0);
        chk("mid_done", 64'(bus.done), 0);
        chk("mid_wdata", bus.WriteData, 0);
        chk("mid_regwr", 64'(bus.RegWrite), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_op(3'd0, 64'd3, 64'd4, 5'd1, 0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [63:0] a, b;
            int          sel;
            op  = 3'($urandom_range(0, 7));
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 0;
            else if (sel == 1) begin a = MIN; b = ONES; end
            else if (sel == 2) begin a = 64'($signed(32'($urandom_range(0, 200)) - 32'd100)); b = 64'($urandom_range(1, 9)); end
            else if (sel == 3) b = {{32{b[31]}}, b[31:0]};
            run_op(op, a, b, 5'($urandom), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
